// File: rtl/logic_unit_pipe.sv
// Registered bitwise logic unit with valid/ready handshakes.
// Ops 110/111 can fold a multi-beat burst into an accumulator.
module logic_unit_pipe #(
  parameter int WIDTH  = 8,
  parameter bit ACC_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [2:0]       in_op,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_zero,
  output logic             out_ones
);

  typedef enum logic {IDLE, ACCUM} state_t;

  state_t           state;
  state_t           state_n;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] acc_n;
  logic [WIDTH-1:0] r;
  logic [WIDTH-1:0] fold;
  logic [WIDTH-1:0] res;
  logic [2:0]       op_q;
  logic [2:0]       op_n;
  logic [2:0]       op_eff;
  logic             accept;
  logic             acc_op;
  logic             produce;

  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;
  assign acc_op   = ACC_EN && (in_op[2:1] == 2'b11);
  assign op_eff   = (state == ACCUM) ? op_q : in_op;

  always_comb begin
    r = '0;
    unique case (op_eff)
      3'b000: r = in_a & in_b;
      3'b001: r = in_a | in_b;
      3'b010: r = in_a ^ in_b;
      3'b011: r = ~(in_a & in_b);
      3'b100: r = ~(in_a | in_b);
      3'b101: r = ~(in_a ^ in_b);
      3'b110: r = in_a & in_b;
      3'b111: r = in_a | in_b;
    endcase
  end

  // op bit 0 picks the fold: 110 folds with AND, 111 with OR
  assign fold = op_q[0] ? (acc | r) : (acc & r);
  assign res  = (state == ACCUM) ? fold : r;

  always_comb begin
    state_n = state;
    acc_n   = acc;
    op_n    = op_q;
    produce = 1'b0;
    unique case (state)
      IDLE: begin
        if (accept) begin
          if (acc_op && !in_last) begin
            state_n = ACCUM;
            acc_n   = r;
            op_n    = in_op;
          end else begin
            produce = 1'b1;
          end
        end
      end
      ACCUM: begin
        if (accept) begin
          if (in_last) begin
            produce = 1'b1;
            acc_n   = '0;
            state_n = IDLE;
          end else begin
            acc_n = fold;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      acc   <= '0;
      op_q  <= 3'b000;
    end else begin
      state <= state_n;
      acc   <= acc_n;
      op_q  <= op_n;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_zero  <= 1'b1;
      out_ones  <= 1'b0;
    end else if (produce) begin
      out_valid <= 1'b1;
      out_data  <= res;
      out_zero  <= (res == '0);
      out_ones  <= &res;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_logic_unit_pipe.sv
// Bench for logic_unit_pipe: ACC_EN=1 and ACC_EN=0 builds
// side by side, checked against a burst-queue model.
module tb_logic_unit_pipe;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_last = 1'b0;
  logic       out_ready = 1'b1;
  logic [7:0] in_a = '0;
  logic [7:0] in_b = '0;
  logic [2:0] in_op = '0;

  logic       rdy1, vld1, z1, o1;
  logic [7:0] d1;
  logic       rdy0, vld0, z0, o0;
  logic [7:0] d0;

  int total = 0;
  int passed = 0;

  always #5 clk = ~clk;

  logic_unit_pipe #(.WIDTH(8), .ACC_EN(1'b1)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(rdy1),
    .in_a(in_a), .in_b(in_b), .in_op(in_op), .in_last(in_last),
    .out_valid(vld1), .out_ready(out_ready),
    .out_data(d1), .out_zero(z1), .out_ones(o1)
  );

  logic_unit_pipe #(.WIDTH(8), .ACC_EN(1'b0)) dut0 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(rdy0),
    .in_a(in_a), .in_b(in_b), .in_op(in_op), .in_last(in_last),
    .out_valid(vld0), .out_ready(out_ready),
    .out_data(d0), .out_zero(z0), .out_ones(o0)
  );

  function automatic logic [7:0] bitop(input logic [2:0] op,
                                       input logic [7:0] a,
                                       input logic [7:0] b);
    case (op)
      3'd0:    return a & b;
      3'd1:    return a | b;
      3'd2:    return a ^ b;
      3'd3:    return ~(a & b);
      3'd4:    return ~(a | b);
      3'd5:    return ~(a ^ b);
      3'd6:    return a & b;
      default: return a | b;
    endcase
  endfunction

  // Model: index 0 is the ACC_EN=1 build, index 1 the ACC_EN=0 build.
  bit         mv [2];
  logic [7:0] md [2];
  bit         inb;
  logic [2:0] bop;
  logic [7:0] bq [$];
  bit         m_prod;
  logic [7:0] m_v;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mv[0] = 1'b0; mv[1] = 1'b0;
      md[0] = '0;   md[1] = '0;
      inb = 1'b0;
      bop = '0;
      bq.delete();
    end else begin
      for (int k = 0; k < 2; k++) begin
        m_prod = 1'b0;
        m_v = '0;
        if (in_valid && (!mv[k] || out_ready)) begin
          if (k == 0 && inb) begin
            bq.push_back(bitop(bop, in_a, in_b));
            if (in_last) begin
              m_v = bq[0];
              foreach (bq[i]) m_v = bop[0] ? (m_v | bq[i]) : (m_v & bq[i]);
              m_prod = 1'b1;
              inb = 1'b0;
              bq.delete();
            end
          end else if (k == 0 && in_op[2:1] == 2'b11 && !in_last) begin
            inb = 1'b1;
            bop = in_op;
            bq.delete();
            bq.push_back(bitop(in_op, in_a, in_b));
          end else begin
            m_prod = 1'b1;
            m_v = bitop(in_op, in_a, in_b);
          end
        end
        if (m_prod) begin
          mv[k] = 1'b1;
          md[k] = m_v;
        end else if (out_ready) begin
          mv[k] = 1'b0;
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [7:0] got,
                     input logic [7:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %h, expected %h", nm, got, exp);
  endtask

  task automatic cmp(input int k, input logic rdy, input logic vld,
                     input logic z, input logic o, input logic [7:0] d);
    chk($sformatf("in_ready[%0d]", k), rdy, !mv[k] || out_ready);
    chk($sformatf("out_valid[%0d]", k), vld, mv[k]);
    if (mv[k]) begin
      chk($sformatf("out_data[%0d]", k), d, md[k]);
      chk($sformatf("out_zero[%0d]", k), z, md[k] == 8'h00);
      chk($sformatf("out_ones[%0d]", k), o, md[k] == 8'hFF);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      cmp(0, rdy1, vld1, z1, o1, d1);
      cmp(1, rdy0, vld0, z0, o0, d0);
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic beat(input logic [7:0] a, input logic [7:0] b,
                      input logic [2:0] op, input logic last);
    in_valid = 1'b1;
    in_a = a;
    in_b = b;
    in_op = op;
    in_last = last;
    step();
  endtask

  task automatic idle();
    in_valid = 1'b0;
    in_last = 1'b0;
    step();
  endtask

  logic [7:0] t1 [6];

  initial begin
    t1 = '{8'h30, 8'hFC, 8'hCC, 8'hCF, 8'h03, 8'h33};

    step();
    step();
    chk("rst_valid", vld1, 1'b0);
    chk("rst_data", d1, 8'h00);
    chk("rst_zero", z1, 1'b1);
    chk("rst_ones", o1, 1'b0);
    rst = 1'b0;
    #1;
    chk("rst_ready", rdy1, 1'b1);

    for (int i = 0; i < 6; i++) begin
      beat(8'hF0, 8'h3C, 3'(i), 1'b0);
      chk($sformatf("op%0d_data", i), d1, t1[i]);
      chk($sformatf("op%0d_valid", i), vld1, 1'b1);
      chk($sformatf("op%0d_flags", i), {z1, o1}, 2'b00);
    end
    idle();

    beat(8'hFF, 8'hF7, 3'd6, 1'b0);
    chk("acc_b1_valid", vld1, 1'b0);
    beat(8'hFE, 8'hFF, 3'd1, 1'b0);
    chk("acc_b2_valid", vld1, 1'b0);
    beat(8'h7F, 8'hFF, 3'd1, 1'b1);
    chk("acc_and_data", d1, 8'h76);
    chk("acc_and_valid", vld1, 1'b1);
    idle();

    out_ready = 1'b0;
    beat(8'hAA, 8'h55, 3'd2, 1'b0);
    in_a = 8'h0F;
    in_b = 8'hF0;
    in_op = 3'd0;
    for (int i = 0; i < 4; i++) begin
      chk("hold_ready", rdy1, 1'b0);
      chk("hold_data", d1, 8'hFF);
      chk("hold_ones", o1, 1'b1);
      step();
    end
    out_ready = 1'b1;
    #1;
    chk("release_ready", rdy1, 1'b1);
    step();
    chk("release_data", d1, 8'h00);
    chk("release_zero", z1, 1'b1);
    idle();

    beat(8'h00, 8'h00, 3'd7, 1'b1);
    chk("acc_or1_data", d1, 8'h00);
    chk("acc_or1_zero", z1, 1'b1);
    chk("acc_or1_valid", vld1, 1'b1);
    beat(8'hFF, 8'hFF, 3'd0, 1'b0);
    chk("after_single_data", d1, 8'hFF);
    chk("after_single_ones", o1, 1'b1);
    idle();

    beat(8'h80, 8'h00, 3'd7, 1'b0);
    beat(8'h00, 8'h40, 3'd7, 1'b0);
    in_valid = 1'b0;
    #1;
    rst = 1'b1;
    #1;
    chk("arst_valid", vld1, 1'b0);
    chk("arst_data", d1, 8'h00);
    chk("arst_zero", z1, 1'b1);
    chk("arst_valid0", vld0, 1'b0);
    step();
    rst = 1'b0;
    beat(8'h01, 8'h00, 3'd7, 1'b1);
    chk("fresh_data", d1, 8'h01);
    chk("fresh_valid", vld1, 1'b1);
    idle();

    beat(8'h0F, 8'hFF, 3'd6, 1'b0);
    chk("noacc_b1_data", d0, 8'h0F);
    chk("noacc_b1_valid", vld0, 1'b1);
    chk("acc_b1_quiet", vld1, 1'b0);
    beat(8'hF0, 8'hFF, 3'd6, 1'b0);
    chk("noacc_b2_data", d0, 8'hF0);
    beat(8'hFF, 8'hFF, 3'd6, 1'b1);
    chk("acc_end_data", d1, 8'h00);
    chk("acc_end_zero", z1, 1'b1);
    chk("noacc_b3_data", d0, 8'hFF);
    idle();
    idle();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
